// File: rtl/mac_rx_mii.sv
// MII receive framer: strips preamble/SFD, assembles bytes from nibbles, checks FCS
// and framing, and streams each frame out with index, last, error and CRC flags.
module mac_rx_mii #(
    parameter int unsigned MAX_BYTES = 1522,
    parameter int unsigned MIN_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mii_rx_dv,
    input  logic        mii_rx_er,
    input  logic [3:0]  mii_rxd,
    output logic        rx_vld,
    output logic        rx_last,
    output logic        rx_err,
    output logic        rx_crc_ok,
    output logic        rx_busy,
    output logic [10:0] rx_addr,
    output logic [7:0]  rx_data
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] MAX_B       = 11'(MAX_BYTES);
    localparam logic [10:0] MIN_B       = 11'(MIN_BYTES);

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    state_t      state, state_next;
    logic        sfd_hit, data_nib, frame_end;
    logic        phase_hi;
    logic [3:0]  lo_nib;
    logic [7:0]  pend_data;
    logic        pend_vld;
    logic [10:0] count;
    logic        er_flag, over_flag;
    logic [31:0] crc;

    // Reflected CRC-32 over one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= DROP;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        sfd_hit    = 1'b0;
        data_nib   = 1'b0;
        frame_end  = 1'b0;
        unique case (state)
            DROP: if (!mii_rx_dv) state_next = IDLE;
            IDLE: if (mii_rx_dv) state_next = (mii_rxd == 4'h5) ? PRE : DROP;
            PRE: begin
                if (!mii_rx_dv)            state_next = IDLE;
                else if (mii_rxd == 4'h5)  state_next = PRE;
                else if (mii_rxd == 4'hD) begin
                    state_next = DATA;
                    sfd_hit    = 1'b1;
                end
                else                       state_next = DROP;
            end
            DATA: begin
                if (mii_rx_dv) data_nib = 1'b1;
                else begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end
            end
            default: state_next = DROP;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            phase_hi  <= 1'b0;
            lo_nib    <= '0;
            pend_data <= '0;
            pend_vld  <= 1'b0;
            count     <= '0;
            er_flag   <= 1'b0;
            over_flag <= 1'b0;
            crc       <= '1;
            rx_vld    <= 1'b0;
            rx_last   <= 1'b0;
            rx_err    <= 1'b0;
            rx_crc_ok <= 1'b0;
            rx_busy   <= 1'b0;
            rx_addr   <= '0;
            rx_data   <= '0;
        end else begin
            rx_vld    <= 1'b0;
            rx_last   <= 1'b0;
            rx_err    <= 1'b0;
            rx_crc_ok <= 1'b0;
            // Busy trails the pending flag by a cycle, so it leads the first byte and
            // drops the cycle after the last one.
            rx_busy   <= pend_vld;

            if (sfd_hit) begin
                phase_hi  <= 1'b0;
                count     <= '0;
                er_flag   <= 1'b0;
                over_flag <= 1'b0;
                crc       <= '1;
                pend_vld  <= 1'b0;
            end

            if (state == DATA && mii_rx_er) er_flag <= 1'b1;

            if (data_nib) begin
                phase_hi <= ~phase_hi;
                if (!phase_hi) begin
                    lo_nib <= mii_rxd;
                end else begin
                    crc <= crc32_byte(crc, {mii_rxd, lo_nib});
                    if (count < MAX_B) begin
                        // A byte is held back one slot so the final one can carry rx_last.
                        if (pend_vld) begin
                            rx_vld  <= 1'b1;
                            rx_data <= pend_data;
                            rx_addr <= count - 11'd1;
                        end
                        pend_data <= {mii_rxd, lo_nib};
                        pend_vld  <= 1'b1;
                        count     <= count + 11'd1;
                    end else begin
                        over_flag <= 1'b1;
                    end
                end
            end

            if (frame_end) begin
                pend_vld <= 1'b0;
                if (pend_vld) begin
                    rx_vld    <= 1'b1;
                    rx_last   <= 1'b1;
                    rx_data   <= pend_data;
                    rx_addr   <= count - 11'd1;
                    rx_err    <= er_flag | mii_rx_er | phase_hi | (count < MIN_B) | over_flag;
                    rx_crc_ok <= (crc == CRC_RESIDUE);
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_rx_mii.sv
// Randomized self-checking bench for mac_rx_mii: frames are built as byte lists with
// FCS, driven as MII nibbles, and the output stream is scored against a frame-level model.
module tb_mac_rx_mii;

    localparam int MAX = 1522;
    localparam int MIN = 64;

    typedef logic [7:0] byte_q[$];
    typedef struct packed {
        logic [10:0] addr;
        logic [7:0]  data;
        logic        last;
        logic        err;
        logic        crc;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mii_rx_dv = 1'b0;
    logic        mii_rx_er = 1'b0;
    logic [3:0]  mii_rxd = 4'h0;
    logic        rx_vld, rx_last, rx_err, rx_crc_ok, rx_busy;
    logic [10:0] rx_addr;
    logic [7:0]  rx_data;

    int errors = 0;
    int checks = 0;
    int viol = 0;
    int busy_cycles = 0;
    logic prev_busy = 1'b0;
    logic prev_last = 1'b0;
    rec_t got_q[$];
    rec_t exp_q[$];

    mac_rx_mii #(.MAX_BYTES(MAX), .MIN_BYTES(MIN)) dut (
        .clk(clk), .reset(reset),
        .mii_rx_dv(mii_rx_dv), .mii_rx_er(mii_rx_er), .mii_rxd(mii_rxd),
        .rx_vld(rx_vld), .rx_last(rx_last), .rx_err(rx_err), .rx_crc_ok(rx_crc_ok),
        .rx_busy(rx_busy), .rx_addr(rx_addr), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_vld) got_q.push_back('{rx_addr, rx_data, rx_last, rx_err, rx_crc_ok});
        if (!rx_vld && (rx_last || rx_err || rx_crc_ok)) viol++;
        if (rx_vld && !(rx_busy && prev_busy)) viol++;
        if (prev_last && rx_busy) viol++;
        if (rx_busy) busy_cycles++;
        prev_busy = rx_busy;
        prev_last = rx_vld && rx_last;
    end

    function automatic logic [31:0] fcs_of(input byte_q q, input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 8; k++)
                c = (c[0] ^ q[i][k]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return ~c;
    endfunction

    function automatic byte_q add_fcs(input byte_q q);
        logic [31:0] f;
        byte_q r;
        r = q;
        f = fcs_of(q, q.size());
        for (int i = 0; i < 4; i++) r.push_back(f[8*i +: 8]);
        return r;
    endfunction

    function automatic byte_q rand_payload(input int n);
        byte_q r;
        for (int i = 0; i < n; i++) r.push_back(8'($urandom));
        return r;
    endfunction

    // Frame-level expectation: delivered bytes, and flags on the last one.
    task automatic model(input byte_q f, input bit er, input bit odd, input int reset_at);
        int  n, n_acc;
        bit  err, crc_ok;
        logic [31:0] fcs_rx;
        n = f.size();
        if (reset_at >= 0) begin
            for (int i = 0; i < reset_at - 1; i++) exp_q.push_back('{11'(i), f[i], 1'b0, 1'b0, 1'b0});
            return;
        end
        if (n == 0) return;
        n_acc  = (n > MAX) ? MAX : n;
        fcs_rx = {f[n-1], f[n-2], f[n-3], f[n-4]};
        crc_ok = (fcs_of(f, n - 4) == fcs_rx);
        err    = er || odd || (n < MIN) || (n > MAX);
        for (int i = 0; i < n_acc; i++) begin
            if (i == n_acc - 1) exp_q.push_back('{11'(i), f[i], 1'b1, err, crc_ok});
            else                exp_q.push_back('{11'(i), f[i], 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic nib(input logic dv, input logic er, input logic [3:0] d, input logic rst);
        mii_rx_dv = dv;
        mii_rx_er = er;
        mii_rxd   = d;
        reset     = rst;
        @(negedge clk);
    endtask

    task automatic send_frame(input byte_q f, input int er_at, input bit odd,
                              input int reset_at, input bit pre_bad, input int ifg);
        for (int k = 0; k < 15; k++) nib(1'b1, 1'b0, (pre_bad && k == 6) ? 4'h7 : 4'h5, 1'b0);
        nib(1'b1, 1'b0, 4'hD, 1'b0);
        for (int i = 0; i < f.size(); i++) begin
            nib(1'b1, er_at == i, f[i][3:0], reset_at == i);
            if (reset_at == i)
                check("reset mid-frame outputs",
                      {rx_vld, rx_last, rx_err, rx_crc_ok, rx_busy, rx_addr, rx_data}, '0);
            nib(1'b1, 1'b0, f[i][7:4], 1'b0);
        end
        if (odd) nib(1'b1, 1'b0, 4'($urandom), 1'b0);
        for (int k = 0; k < ifg; k++) nib(1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic compare_batch(input string tag);
        int mism, n;
        repeat (4) nib(1'b0, 1'b0, 4'h0, 1'b0);
        check({tag, " byte count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        mism = 0;
        for (int i = 0; i < n; i++) begin
            if (got_q[i] !== exp_q[i]) begin
                if (mism == 0) $display("  %s first diff at %0d: got %h expected %h", tag, i, got_q[i], exp_q[i]);
                mism++;
            end
        end
        check({tag, " byte diffs"}, mism, 0);
        if (n > 0) check({tag, " last flags"}, {got_q[n-1].last, got_q[n-1].err, got_q[n-1].crc},
                         {exp_q[n-1].last, exp_q[n-1].err, exp_q[n-1].crc});
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin : stim
        byte_q udp, f, empty;
        int kind, er_at, ifg;
        bit odd;

        udp = '{8'h98, 8'h5a, 8'heb, 8'hdd, 8'h1c, 8'h65, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h08, 8'h00,
                8'h45, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11, 8'h00, 8'h00,
                8'hc0, 8'ha8, 8'h02, 8'h01, 8'hc0, 8'ha8, 8'h02, 8'h05,
                8'h04, 8'hd2, 8'h4e, 8'h50, 8'h00, 8'h0c, 8'h00, 8'h00,
                8'h01, 8'h02, 8'h03, 8'h04};
        while (udp.size() < 60) udp.push_back(8'h00);
        udp = add_fcs(udp);

        @(negedge clk);
        repeat (3) nib(1'b0, 1'b0, 4'h0, 1'b1);
        check("reset outputs", {rx_vld, rx_last, rx_err, rx_crc_ok, rx_busy, rx_addr, rx_data}, '0);
        nib(1'b0, 1'b0, 4'h0, 1'b0);

        // Good UDP frame
        model(udp, 0, 0, -1);
        send_frame(udp, -1, 0, -1, 0, 2);
        repeat (4) nib(1'b0, 1'b0, 4'h0, 1'b0);
        check("first byte", (got_q.size() > 0) ? got_q[0].data : 8'hxx, 8'h98);
        check("udp payload", (got_q.size() >= 46) ?
              {got_q[42].data, got_q[43].data, got_q[44].data, got_q[45].data} : 32'hx, 32'h01020304);
        compare_batch("good");

        // Payload bit flip after FCS
        f = udp; f[43][5] = ~f[43][5];
        model(f, 0, 0, -1); send_frame(f, -1, 0, -1, 0, 2); compare_batch("bitflip");

        // rx_er at byte 20, then odd nibble count
        model(udp, 1, 0, -1); send_frame(udp, 20, 0, -1, 0, 2); compare_batch("rx_er");
        model(udp, 0, 1, -1); send_frame(udp, -1, 1, -1, 0, 2); compare_batch("odd nibble");

        // Runt and oversize
        f = add_fcs(rand_payload(36));
        model(f, 0, 0, -1); send_frame(f, -1, 0, -1, 0, 2); compare_batch("runt");
        f = add_fcs(rand_payload(1596));
        model(f, 0, 0, -1); send_frame(f, -1, 0, -1, 0, 2); compare_batch("oversize");

        // Bad preamble, then SFD with no data: no output and no busy
        busy_cycles = 0;
        send_frame(udp, -1, 0, -1, 1, 2);
        send_frame(empty, -1, 0, -1, 0, 2);
        compare_batch("dropped");
        check("dropped busy cycles", busy_cycles, 0);
        model(udp, 0, 0, -1); send_frame(udp, -1, 0, -1, 0, 2); compare_batch("after drop");

        // Reset mid-frame with dv held high, then a clean frame
        model(udp, 0, 0, 30); send_frame(udp, -1, 0, 30, 0, 2); compare_batch("reset frame");
        model(udp, 0, 0, -1); send_frame(udp, -1, 0, -1, 0, 1); compare_batch("after reset");

        // Randomized back-to-back frames
        for (int t = 0; t < 16; t++) begin
            kind  = $urandom_range(0, 3);
            f     = add_fcs(rand_payload($urandom_range(20, 150)));
            er_at = (kind == 2) ? $urandom_range(0, f.size() - 1) : -1;
            odd   = (kind == 3);
            if (kind == 1) begin
                int b;
                b = $urandom_range(0, f.size() - 1);
                f[b][$urandom_range(0, 7)] ^= 1'b1;
            end
            ifg = $urandom_range(1, 3);
            model(f, kind == 2, odd, -1);
            send_frame(f, er_at, odd, -1, 0, ifg);
        end
        compare_batch("random");

        check("protocol violations", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
